// File: rtl/net_arb_pkg.sv
// Shared types and helpers for the network TX packet arbiter.
package net_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    localparam int MAX_PORTS = 8;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

    // Returns {found, idx}: first set bit of req searching from ptr+1 upward, modulo n.
    function automatic logic [3:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                           input int ptr, input int n);
        logic       found;
        logic [2:0] idx;
        int         p;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            p = (ptr + k) % n;
            if (k <= n && !found && req[p]) begin
                found = 1'b1;
                idx   = p[2:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: lowest-priority slot is the last winner rr_ptr.
module rr_priority_select
    import net_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:0] grant_onehot,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    logic [MAX_PORTS-1:0] req_ext;
    logic [3:0]           pick;

    always_comb begin
        req_ext                  = '0;
        req_ext[NUM_PORTS-1:0]   = req;
        pick                     = rr_pick(req_ext, int'(rr_ptr), NUM_PORTS);
        grant_valid              = pick[3];
        grant_idx                = pick[IDX_W-1:0];
        grant_onehot             = '0;
        grant_onehot[grant_idx]  = grant_valid;
    end

endmodule

// File: rtl/net_tx_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS AXIS requesters onto one TX stream.
module net_tx_arbiter
    import net_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 512,
    parameter int CNT_WIDTH  = 32,
    parameter int KEEP_WIDTH = keep_width(DATA_WIDTH)
) (
    input  logic                            user_clk,
    input  logic                            sys_reset,
    input  logic                            link_up,
    input  logic [NUM_PORTS-1:0]            port_enable,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [NUM_PORTS-1:0]            grant_onehot,
    output logic                            busy,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_state_e                              state_q, state_d;
    logic [NUM_PORTS-1:0]                    grant_oh_q;
    logic [IDX_W-1:0]                        grant_idx_q;
    logic [IDX_W-1:0]                        rr_ptr_q;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]     cnt_q;

    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    data_v;
    logic [NUM_PORTS-1:0][KEEP_WIDTH-1:0]    keep_v;
    logic [NUM_PORTS-1:0]                    req;
    logic [NUM_PORTS-1:0]                    sel_oh;
    logic [IDX_W-1:0]                        sel_idx;
    logic                                    sel_valid;
    logic                                    locked;
    logic                                    pkt_done;

    assign data_v       = s_axis_tdata;
    assign keep_v       = s_axis_tkeep;
    assign req          = s_axis_tvalid & port_enable & {NUM_PORTS{link_up}};
    assign locked       = (state_q == LOCKED);
    assign busy         = locked;
    assign grant_onehot = grant_oh_q;
    assign pkt_count    = cnt_q;

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_sel (
        .req          (req),
        .rr_ptr       (rr_ptr_q),
        .grant_onehot (sel_oh),
        .grant_idx    (sel_idx),
        .grant_valid  (sel_valid)
    );

    // Zero-latency datapath: owner's beat goes straight through while locked.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = data_v[grant_idx_q];
        m_axis_tkeep  = keep_v[grant_idx_q];
        m_axis_tlast  = s_axis_tlast[grant_idx_q];
        s_axis_tready = '0;
        if (locked) begin
            m_axis_tvalid              = s_axis_tvalid[grant_idx_q];
            s_axis_tready[grant_idx_q] = m_axis_tready;
        end
    end

    assign pkt_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_valid) state_d = LOCKED;
            LOCKED:  if (pkt_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (sys_reset) begin
            state_q     <= IDLE;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= IDX_W'(NUM_PORTS - 1);
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            if (!locked && sel_valid) begin
                grant_oh_q  <= sel_oh;
                grant_idx_q <= sel_idx;
            end
            if (pkt_done) begin
                rr_ptr_q   <= grant_idx_q;
                grant_oh_q <= '0;
                for (int i = 0; i < NUM_PORTS; i++)
                    if (grant_idx_q == IDX_W'(i)) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Directed self-checking bench for net_tx_arbiter.
module tb_net_tx_arbiter;

    localparam int NP = 4;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int CW = 32;

    logic              user_clk = 1'b0;
    logic              sys_reset;
    logic              link_up;
    logic [NP-1:0]     port_enable;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tready;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP*KW-1:0]  s_axis_tkeep;
    logic [NP-1:0]     s_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tlast;
    logic [NP-1:0]     grant_onehot;
    logic              busy;
    logic [NP*CW-1:0]  pkt_count;

    // Narrow-counter instance sharing all inputs, used to exercise counter wrap.
    logic [NP-1:0]     s2_tready;
    logic              s2_tvalid;
    logic [DW-1:0]     s2_tdata;
    logic [KW-1:0]     s2_tkeep;
    logic              s2_tlast;
    logic [NP-1:0]     s2_grant;
    logic              s2_busy;
    logic [NP*2-1:0]   s2_count;

    int checks   = 0;
    int failures = 0;

    always #5 user_clk = ~user_clk;

    net_tx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .user_clk(user_clk), .sys_reset(sys_reset), .link_up(link_up),
        .port_enable(port_enable), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .grant_onehot(grant_onehot),
        .busy(busy), .pkt_count(pkt_count)
    );

    net_tx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_small (
        .user_clk(user_clk), .sys_reset(sys_reset), .link_up(link_up),
        .port_enable(port_enable), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s2_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(s2_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(s2_tdata), .m_axis_tkeep(s2_tkeep),
        .m_axis_tlast(s2_tlast), .grant_onehot(s2_grant),
        .busy(s2_busy), .pkt_count(s2_count)
    );

    function automatic logic [DW-1:0] pat(input int port, input int beat);
        logic [7:0] p8, b8;
        p8 = 8'(port);
        b8 = 8'(beat);
        return {16{p8, b8, 16'hA5C3}};
    endfunction

    function automatic logic [CW-1:0] cnt(input int port);
        return pkt_count[port*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge user_clk);
        #2;
    endtask

    task automatic set_port(input int p, input logic v, input int beat, input logic last);
        s_axis_tvalid[p]         = v;
        s_axis_tdata[p*DW +: DW] = pat(p, beat);
        s_axis_tkeep[p*KW +: KW] = last ? {{(KW/2){1'b0}}, {(KW/2){1'b1}}} : {KW{1'b1}};
        s_axis_tlast[p]          = last;
    endtask

    task automatic do_reset();
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        port_enable   = '1;
        link_up       = 1'b1;
        sys_reset     = 1'b1;
        tick();
        sys_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || busy !== 1'b0) begin
            $display("FAIL reset_outputs tvalid=%b tready=%b busy=%b want 0/0000/0",
                     m_axis_tvalid, s_axis_tready, busy);
            failures++;
        end
        checks++;
        if (grant_onehot !== '0 || pkt_count !== '0) begin
            $display("FAIL reset_state grant=%b count=%h want 0", grant_onehot, pkt_count);
            failures++;
        end
    endtask

    task automatic test_single_packet();
        do_reset();
        set_port(0, 1'b1, 0, 1'b0);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000) begin
            $display("FAIL single_arb_cycle tvalid=%b tready=%b want 0/0000", m_axis_tvalid, s_axis_tready);
            failures++;
        end
        tick();
        for (int b = 0; b < 3; b++) begin
            set_port(0, 1'b1, b, b == 2);
            #1;
            checks++;
            if (grant_onehot !== 4'b0001 || !busy || m_axis_tvalid !== 1'b1 ||
                m_axis_tdata !== pat(0, b) || m_axis_tlast !== (b == 2) ||
                m_axis_tkeep !== s_axis_tkeep[0 +: KW] || s_axis_tready !== 4'b0001) begin
                $display("FAIL single_beat%0d grant=%b tvalid=%b tlast=%b tready=%b data_ok=%b want 0001/1/%0d/0001/1",
                         b, grant_onehot, m_axis_tvalid, m_axis_tlast, s_axis_tready,
                         m_axis_tdata === pat(0, b), b == 2);
                failures++;
            end
            tick();
        end
        set_port(0, 1'b0, 0, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b0 || grant_onehot !== '0 || cnt(0) !== 32'd1) begin
            $display("FAIL single_done busy=%b grant=%b count0=%0d want 0/0000/1", busy, grant_onehot, cnt(0));
            failures++;
        end
    endtask

    task automatic test_round_robin();
        int exp_p;
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 7, 1'b1);
        for (int k = 0; k < 8; k++) begin
            exp_p = k % NP;
            #1;
            checks++;
            if (m_axis_tvalid !== 1'b0) begin
                $display("FAIL rr_gap%0d tvalid=%b want 0", k, m_axis_tvalid);
                failures++;
            end
            tick();
            checks++;
            if (m_axis_tvalid !== 1'b1 || grant_onehot !== 4'(1 << exp_p) ||
                m_axis_tdata !== pat(exp_p, 7)) begin
                $display("FAIL rr_pkt%0d grant=%b tvalid=%b want grant=%b tvalid=1",
                         k, grant_onehot, m_axis_tvalid, 4'(1 << exp_p));
                failures++;
            end
            tick();
        end
        s_axis_tvalid = '0;
        #1;
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (cnt(p) !== 32'd2) begin
                $display("FAIL rr_count%0d got=%0d want 2", p, cnt(p));
                failures++;
            end
        end
    endtask

    task automatic test_no_interleave();
        do_reset();
        set_port(1, 1'b1, 0, 1'b0);
        tick();
        set_port(2, 1'b1, 9, 1'b1);
        for (int b = 0; b < 3; b++) begin
            set_port(1, 1'b1, b, b == 2);
            #1;
            checks++;
            if (grant_onehot !== 4'b0010 || s_axis_tready !== 4'b0010 || m_axis_tdata !== pat(1, b)) begin
                $display("FAIL nointl_beat%0d grant=%b tready=%b want 0010/0010", b, grant_onehot, s_axis_tready);
                failures++;
            end
            tick();
        end
        s_axis_tvalid[1] = 1'b0;
        #1;
        checks++;
        if (grant_onehot !== '0 || s_axis_tready !== '0 || m_axis_tvalid !== 1'b0) begin
            $display("FAIL nointl_idle grant=%b tready=%b tvalid=%b want 0000/0000/0",
                     grant_onehot, s_axis_tready, m_axis_tvalid);
            failures++;
        end
        tick();
        checks++;
        if (grant_onehot !== 4'b0100 || s_axis_tready !== 4'b0100 || m_axis_tdata !== pat(2, 9)) begin
            $display("FAIL nointl_port2 grant=%b tready=%b want 0100/0100", grant_onehot, s_axis_tready);
            failures++;
        end
        tick();
        s_axis_tvalid = '0;
    endtask

    task automatic test_backpressure();
        int b;
        int cyc;
        do_reset();
        b   = 0;
        cyc = 0;
        set_port(0, 1'b1, 0, 1'b0);
        tick();
        while (b < 4 && cyc < 20) begin
            m_axis_tready = (cyc % 2 == 0);
            set_port(0, 1'b1, b, b == 3);
            #1;
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pat(0, b) ||
                s_axis_tready !== {3'b000, m_axis_tready} || m_axis_tlast !== (b == 3)) begin
                $display("FAIL bp_cyc%0d beat=%0d tvalid=%b tready=%b tlast=%b data_ok=%b want 1/%b/%0d",
                         cyc, b, m_axis_tvalid, s_axis_tready, m_axis_tlast,
                         m_axis_tdata === pat(0, b), m_axis_tready, b == 3);
                failures++;
            end
            if (m_axis_tready) b++;
            cyc++;
            tick();
        end
        s_axis_tvalid = '0;
        m_axis_tready = 1'b1;
        #1;
        checks++;
        if (b != 4 || busy !== 1'b0 || cnt(0) !== 32'd1) begin
            $display("FAIL bp_done beats=%0d busy=%b count0=%0d want 4/0/1", b, busy, cnt(0));
            failures++;
        end
    endtask

    task automatic test_enable_link();
        int order [4] = '{0, 1, 3, 0};
        do_reset();
        link_up     = 1'b0;
        port_enable = 4'b1011;
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (grant_onehot !== '0 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL link_down%0d grant=%b tvalid=%b want 0000/0", k, grant_onehot, m_axis_tvalid);
                failures++;
            end
        end
        link_up = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (grant_onehot !== 4'(1 << order[k]) || m_axis_tvalid !== 1'b1) begin
                $display("FAIL enable_pkt%0d grant=%b want %b", k, grant_onehot, 4'(1 << order[k]));
                failures++;
            end
            tick();
        end
        s_axis_tvalid = '0;
        #1;
        checks++;
        if (cnt(2) !== 32'd0 || cnt(0) !== 32'd2) begin
            $display("FAIL enable_counts c2=%0d c0=%0d want 0/2", cnt(2), cnt(0));
            failures++;
        end
        port_enable = '1;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_port(1, 1'b1, 0, 1'b1);
        tick();
        tick();
        s_axis_tvalid[1] = 1'b0;
        set_port(0, 1'b1, 0, 1'b0);
        tick();
        tick();
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || grant_onehot !== '0 || m_axis_tvalid !== 1'b0 ||
            s_axis_tready !== '0 || pkt_count !== '0) begin
            $display("FAIL reset_mid busy=%b grant=%b tvalid=%b tready=%b count=%h want all 0",
                     busy, grant_onehot, m_axis_tvalid, s_axis_tready, pkt_count);
            failures++;
        end
        s_axis_tvalid = '0;
    endtask

    task automatic test_counter_wrap();
        do_reset();
        set_port(0, 1'b1, 1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            tick();
            #1;
            checks++;
            if (s2_count[1:0] !== 2'(k) || cnt(0) !== 32'(k) || s2_busy !== 1'b0) begin
                $display("FAIL wrap_pkt%0d small=%0d wide=%0d busy=%b want %0d/%0d/0",
                         k, s2_count[1:0], cnt(0), s2_busy, k % 4, k);
                failures++;
            end
        end
        s_axis_tvalid = '0;
    endtask

    initial begin
        sys_reset     = 1'b1;
        link_up       = 1'b0;
        port_enable   = '0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_no_interleave();
        test_backpressure();
        test_enable_link();
        test_reset_mid_packet();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
